// File: rtl/soc_system_led_driver.sv
// LED driver for the SoC PIO: 16-cycle PWM frames with static, blink, chase and
// full-on modes, and a control word shadowed at frame boundaries.
module soc_system_led_driver #(
    parameter int LED_COUNT = 10,
    parameter int TICK_DIV  = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          ctrl_in,
    output logic [LED_COUNT-1:0] led_out,
    output logic                 frame_start
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    POS_MAX   = 4'(LED_COUNT - 1);
    localparam logic [23:0]   SHADOW_RST = 24'h00FFFF;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_FULL   = 2'b11
    } mode_e;

    logic [3:0]           pwm_cnt_q, pwm_cnt_d;
    logic [23:0]          shadow_q, shadow_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [7:0]           step_cnt_q, step_cnt_d;
    logic                 phase_q, phase_d;
    logic [3:0]           pos_q, pos_d;
    logic [LED_COUNT-1:0] led_q, led_d;
    logic                 frame_q, frame_d;

    mode_e      mode;
    logic [3:0] duty;
    logic [7:0] eff_period;
    logic       tick, step, load, mode_chg, pwm_en, gate;
    logic       unused_ctrl;

    assign mode        = mode_e'(shadow_q[15:14]);
    assign duty        = shadow_q[13:10];
    assign eff_period  = (shadow_q[23:16] == 8'd0) ? 8'd1 : shadow_q[23:16];
    assign unused_ctrl = ^ctrl_in[31:24];

    assign tick     = (presc_q == PRESC_MAX);
    // >= rather than == so a period shrunk below the running count steps on the next tick.
    assign step     = tick && (({1'b0, step_cnt_q} + 9'd1) >= {1'b0, eff_period});
    assign load     = (pwm_cnt_q == 4'd15);
    assign mode_chg = load && (ctrl_in[15:14] != shadow_q[15:14]);
    assign pwm_en   = (mode == MODE_FULL) || (pwm_cnt_q < duty);

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 4'd1;
        shadow_d   = load ? ctrl_in[23:0] : shadow_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        step_cnt_d = step ? 8'd0 : (tick ? step_cnt_q + 8'd1 : step_cnt_q);
        phase_d    = phase_q;
        pos_d      = pos_q;
        frame_d    = (pwm_cnt_q == 4'd0);

        if (step && mode == MODE_BLINK) begin
            phase_d = ~phase_q;
        end
        if (step && mode == MODE_CHASE) begin
            pos_d = (pos_q == POS_MAX) ? 4'd0 : pos_q + 4'd1;
        end
        if (mode_chg) begin
            presc_d    = '0;
            step_cnt_d = 8'd0;
            pos_d      = 4'd0;
            phase_d    = 1'b1;
        end

        led_d = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            case (mode)
                MODE_BLINK: gate = phase_q;
                MODE_CHASE: gate = (pos_q == 4'(i));
                default:    gate = 1'b1;
            endcase
            led_d[i] = (i < 10) && shadow_q[i] && pwm_en && gate;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_q  <= 4'd0;
            shadow_q   <= SHADOW_RST;
            presc_q    <= '0;
            step_cnt_q <= 8'd0;
            phase_q    <= 1'b1;
            pos_q      <= 4'd0;
            led_q      <= '0;
            frame_q    <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            shadow_q   <= shadow_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            led_q      <= led_d;
            frame_q    <= frame_d;
        end
    end

    assign led_out     = led_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_soc_system_led_driver.sv
// Bench for soc_system_led_driver: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized control words and resets.
module tb_soc_system_led_driver;

    localparam int LED_COUNT = 10;
    localparam int TICK_DIV  = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [31:0]          ctrl_in = 32'h0000FFFF;
    logic [LED_COUNT-1:0] led_out;
    logic                 frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    soc_system_led_driver #(.LED_COUNT(LED_COUNT), .TICK_DIV(TICK_DIV)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ctrl_in(ctrl_in),
        .led_out(led_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycle position in frame, tick/step counts, blink phase, chase slot.
    int                   m_pwm, m_presc, m_stepc, m_pos;
    bit                   m_phase;
    logic [31:0]          m_shadow;
    logic [LED_COUNT-1:0] m_led;
    bit                   m_frame;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pwm = 0; m_presc = 0; m_stepc = 0; m_pos = 0; m_phase = 1;
                m_shadow = 32'h0000FFFF; m_led = '0; m_frame = 0;
            end else begin
                int  mode, duty, period;
                bit  tick, step, lit;
                mode   = int'(m_shadow[15:14]);
                duty   = int'(m_shadow[13:10]);
                period = int'(m_shadow[23:16]);
                if (period == 0) period = 1;
                for (int i = 0; i < LED_COUNT; i++) begin
                    lit = (i < 10) && m_shadow[i] && (mode == 3 || m_pwm < duty);
                    if (mode == 1) lit = lit && m_phase;
                    if (mode == 2) lit = lit && (i == m_pos);
                    m_led[i] = lit;
                end
                m_frame = (m_pwm == 0);
                tick    = (m_presc == TICK_DIV - 1);
                m_presc = (m_presc + 1) % TICK_DIV;
                step    = 0;
                if (tick) begin
                    m_stepc++;
                    if (m_stepc >= period) begin
                        step = 1;
                        m_stepc = 0;
                    end
                end
                if (step && mode == 1) m_phase = !m_phase;
                if (step && mode == 2) m_pos = (m_pos + 1) % LED_COUNT;
                if (m_pwm == 15) begin
                    if (int'(ctrl_in[15:14]) != mode) begin
                        m_presc = 0; m_stepc = 0; m_pos = 0; m_phase = 1;
                    end
                    m_shadow = ctrl_in;
                end
                m_pwm = (m_pwm + 1) % 16;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_cycle", {21'd0, frame_start, led_out}, {21'd0, m_frame, m_led});
        end
    end

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 40);
        if (!frame_start) check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_lit(input int cycles, input int bit_idx, output int lit, output int others);
        lit = 0;
        others = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (led_out[bit_idx]) lit++;
            if ((led_out & ~(10'd1 << bit_idx)) != 0) others++;
        end
    endtask

    initial begin
        int n, lit, others, prev_pos, cur_pos, bad_seq, old_bad, found;
        bit wrap_seen;

        repeat (3) @(negedge clk);
        check("reset_led", {22'd0, led_out}, 32'd0);
        check("reset_frame", {31'd0, frame_start}, 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("release_full_on", {22'd0, led_out}, 32'h3FF);
        check("release_frame_start", {31'd0, frame_start}, 32'd1);
        wait_frame(n);
        check("frame_period", n, 16);

        // Static duty 10, then duty 0.
        ctrl_in = 32'h00002BFF;
        wait_frame(n); wait_frame(n);
        count_lit(16, 0, lit, others);
        check("static_duty10_lit", lit, 10);
        ctrl_in = 32'h000003FF;
        wait_frame(n); wait_frame(n);
        count_lit(32, 0, lit, others);
        check("static_duty0_off", lit + others, 0);

        // Blink, duty 15, period 2: 8 on / 8 off on LED 0 only.
        ctrl_in = 32'h00027C01;
        wait_frame(n); wait_frame(n);
        count_lit(64, 0, lit, others);
        check("blink_lit_count", lit, 32);
        check("blink_others_off", others, 0);

        // Chase, period 1: single LED walks 0..9 and wraps.
        ctrl_in = 32'h0001BFFF;
        wait_frame(n); wait_frame(n);
        prev_pos = -1; bad_seq = 0; wrap_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (led_out != 0) begin
                cur_pos = -1;
                for (int j = 0; j < LED_COUNT; j++) if (led_out == (10'd1 << j)) cur_pos = j;
                if (cur_pos < 0) bad_seq++;
                else if (prev_pos >= 0 && cur_pos != prev_pos && cur_pos != (prev_pos + 1) % LED_COUNT) bad_seq++;
                if (prev_pos == 9 && cur_pos == 0) wrap_seen = 1;
                prev_pos = cur_pos;
            end
        end
        check("chase_sequence", bad_seq, 0);
        check("chase_wrap_9_to_0", {31'd0, wrap_seen}, 32'd1);

        // Asynchronous reset while the chase sits on LED 6.
        found = 0;
        for (int k = 0; k < 200 && found == 0; k++) begin
            @(negedge clk);
            if (led_out == 10'h040) found = 1;
        end
        check("chase_reached_pos6", found, 1);
        #3 reset_n = 1'b0;
        #1 check("async_reset_led", {22'd0, led_out}, 32'd0);
        check("async_reset_frame", {31'd0, frame_start}, 32'd0);
        ctrl_in = 32'h0000FFFF;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rerelease_full_on", {22'd0, led_out}, 32'h3FF);
        check("rerelease_frame_start", {31'd0, frame_start}, 32'd1);

        // Mid-frame change at pwm_cnt 5: old word to frame end, new word after.
        wait_frame(n);
        repeat (4) @(negedge clk);
        ctrl_in = 32'h000003FF;
        old_bad = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (led_out != 10'h3FF || frame_start) old_bad++;
        end
        check("midframe_old_word_held", old_bad, 0);
        @(negedge clk);
        check("midframe_new_word", {21'd0, frame_start, led_out}, {21'd0, 1'b1, 10'h000});

        // Randomized control words and occasional resets.
        for (int k = 0; k < 120; k++) begin
            ctrl_in = $urandom;
            ctrl_in[23:16] = 8'($urandom_range(0, 3));
            repeat ($urandom_range(1, 40)) @(negedge clk);
            if ($urandom_range(0, 29) == 0) begin
                #3 reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 reset_n = 1'b1;
            end
        end
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_system_led_driver.md
SOC_SYSTEM_LED_DRIVER -- requirements
Module: soc_system_led_driver

Interface
REQ-001 Parameter LED_COUNT, default 10: number of physical LEDs driven, range 1..16.
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per timebase tick, minimum 1.
REQ-003 Port clk  input  1: single clock; all state on its rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port ctrl_in  input  32: control word from the LED PIO out_port, stable between Avalon writes.
REQ-006 Port led_out  output  LED_COUNT: registered LED drive, 1 = lit.
REQ-007 Port frame_start  output  1: registered one-cycle pulse marking the first cycle of each PWM frame.

Function
REQ-008 The block SHALL decode ctrl_in as: [9:0] enable mask, [13:10] duty (0..15), [15:14] mode, [23:16] step period in ticks, [31:24] ignored.
REQ-009 Mask bits at index LED_COUNT and above SHALL be ignored.
REQ-010 Modes SHALL be: 00 static PWM, 01 blink, 10 chase, 11 full-on (duty bypassed).
REQ-011 A 4-bit PWM counter SHALL increment every cycle and wrap 15 -> 0; one frame = 16 cycles.
REQ-012 ctrl_in SHALL be sampled into a shadow register only in the cycle where the PWM counter is 15; mid-frame changes take effect at the next frame start.
REQ-013 frame_start SHALL be high in the cycle the PWM counter is 0.
REQ-014 PWM enable SHALL be (pwm_cnt < duty); duty 0 gives constantly off, duty 15 gives 15/16 on; mode 11 gives constantly on.
REQ-015 A prescaler SHALL count 0..TICK_DIV-1 and emit a tick in the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-016 A step counter SHALL count ticks and emit a step when it reaches the step period; it then returns to 0; period 0 SHALL be treated as 1.
REQ-017 In blink mode, each step SHALL toggle a phase bit; LEDs are lit only while phase = 1.
REQ-018 In chase mode, each step SHALL advance the chase position by 1, wrapping LED_COUNT-1 -> 0; only the LED at that position is a candidate.
REQ-019 Output: led_out[i] <= mask[i] AND PWM enable AND mode gate (static/full-on: 1; blink: phase; chase: i == position).
REQ-020 led_out SHALL lag its inputs (shadow, PWM counter, phase, position) by exactly one cycle.
REQ-021 A shadow mode change SHALL clear prescaler, step counter, and chase position, and set phase to 1, in the same cycle the shadow loads.
REQ-022 If a step and a mode change coincide, the mode-change clear SHALL win.
REQ-023 A period change without a mode change SHALL NOT clear the counters; if the step counter already exceeds the new period, the step SHALL fire on the next tick.

Reset
REQ-024 While reset_n = 0: led_out = 0, frame_start = 0, PWM counter = 0, prescaler = 0, step counter = 0, phase = 1, chase position = 0, shadow = 0x0000FFFF (matches the PIO reset value: all on, mode 11).
REQ-025 Reset assertion mid-frame or mid-step SHALL force all REQ-024 values immediately; the first frame_start SHALL occur in the first cycle after release.

Verification (TICK_DIV = 4, LED_COUNT = 10)
REQ-026 Release reset, ctrl_in = 0x0000FFFF -> led_out = 0x3FF from the first post-reset edge onward; frame_start every 16 cycles.
REQ-027 ctrl_in = 0x00002BFF (static, duty 10) -> each LED is high for exactly 10 of 16 cycles per frame, pwm_cnt 0..9; ctrl_in = 0x000003FF -> led_out constantly 0.
REQ-028 ctrl_in = 0x00027C01 (blink, duty 15, mask 0x001, period 2) -> led_out[0] PWM-active for 8 cycles, off for 8 cycles, repeating; all other bits 0.
REQ-029 ctrl_in = 0x0001BFFF (chase, period 1) -> single lit LED advances every 4 cycles 0,1,...,9,0; the wrap 9 -> 0 is checked.
REQ-030 Change ctrl_in at pwm_cnt = 5 -> led_out follows the old word until the frame end, and the new word from the next frame.
REQ-031 Assert reset_n during chase at position 6 -> led_out = 0 asynchronously; after release, full-on 0x3FF behaviour per REQ-026.
